// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy,
// sticky error flags, synchronous flush and an optional first-word-fall-through
// read port.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Status flags decode from the registered count only, so they never glitch.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == CNT_W'(0));
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  // A full FIFO still takes a write when a pop frees a slot in the same cycle.
  always_comb begin
    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
  end

  // Pointers, occupancy and sticky errors; flush overrides any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && !rd_acc) underflow <= 1'b1;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem[wr_ptr] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; zero while nothing is stored.
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    // Registered read: the popped word appears one cycle after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out <= '0;
      end else if (flush) begin
        data_out <= '0;
      end else if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-read and a FWFT instance
// share one stimulus stream; popped words are checked by a separate monitor.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;

  logic [7:0] std_data, fw_data;
  logic       std_full, std_empty, std_af, std_ae, std_ovf, std_unf;
  logic       fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf;
  logic [4:0] std_count, fw_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] model[$];
  logic [7:0] sb[$];
  logic       exp_pop;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(std_data), .full(std_full), .empty(std_empty),
    .almost_full(std_af), .almost_empty(std_ae), .count(std_count),
    .overflow(std_ovf), .underflow(std_unf)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(fw_data), .full(fw_full), .empty(fw_empty),
    .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
    .overflow(fw_ovf), .underflow(fw_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock of stimulus; wacc/pop tell the reference model what should be accepted.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic wacc, input logic pop, input logic fl);
    wr_en = w; data_in = d; rd_en = r; flush = fl; exp_pop = pop;
    if (pop) sb.push_back(model.pop_front());
    if (wacc) model.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; exp_pop = 1'b0;
  endtask

  // Monitor: a pop accepted at an edge must show its word on data_out by the next negedge.
  initial begin
    logic p;
    forever begin
      @(posedge clk);
      p = exp_pop;
      @(negedge clk);
      if (p) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underrun: got pop expected none");
        end else begin
          check("std_data_out", 32'(std_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00; exp_pop = 1'b0;
    #12;
    check("rst_count", 32'(std_count), 32'd0);
    check("rst_empty", 32'(std_empty), 32'd1);
    check("rst_ae",    32'(std_ae),    32'd1);
    check("rst_full",  32'(std_full),  32'd0);
    check("rst_af",    32'(std_af),    32'd0);
    check("rst_data",  32'(std_data),  32'd0);
    check("rst_ovf",   32'(std_ovf),   32'd0);
    check("rst_unf",   32'(std_unf),   32'd0);
    check("rst_fw_data", 32'(fw_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 13) check("af_at_13", 32'(std_af), 32'd0);
      if (i == 14) check("af_at_14", 32'(std_af), 32'd1);
    end
    check("fill_full",  32'(std_full),  32'd1);
    check("fill_count", 32'(std_count), 32'd16);
    check("fill_fw_head", 32'(fw_data), 32'h01);

    // Simultaneous read/write while full
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rw_full_count", 32'(std_count), 32'd16);
    check("rw_full_ovf",   32'(std_ovf),   32'd0);
    check("rw_full_fw_head", 32'(fw_data), 32'h02);

    // Rejected write into full FIFO
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_flag",  32'(std_ovf),   32'd1);
    check("ovf_count", 32'(std_count), 32'd16);
    check("ovf_unf",   32'(std_unf),   32'd0);

    // Drain: expect 0x02..0x10 then 0x55, never 0xAA
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      if (k == 13) check("ae_at_3", 32'(std_ae), 32'd0);
      if (k == 14) check("ae_at_2", 32'(std_ae), 32'd1);
    end
    @(negedge clk); #1;
    check("drain_empty", 32'(std_empty), 32'd1);
    check("drain_count", 32'(std_count), 32'd0);
    check("drain_fw_data", 32'(fw_data), 32'd0);

    // Rejected read from empty FIFO keeps data_out
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("unf_flag", 32'(std_unf),  32'd1);
    check("unf_hold", 32'(std_data), 32'h55);
    check("unf_count", 32'(std_count), 32'd0);

    // Flush clears error flags and data_out
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_ovf",  32'(std_ovf),  32'd0);
    check("flush_unf",  32'(std_unf),  32'd0);
    check("flush_data", 32'(std_data), 32'd0);

    // Simultaneous read/write on empty: write lands, read rejected
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rw_empty_count", 32'(std_count), 32'd1);
    check("rw_empty_unf",   32'(std_unf),   32'd1);
    check("rw_empty_fw",    32'(fw_data),   32'h77);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    model.delete();
    check("flush2_count", 32'(std_count), 32'd0);

    // Pointer wrap with interleaved write/read pairs
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      check("wrap_count1", 32'(std_count), 32'd1);
      check("wrap_fw_head", 32'(fw_data), 32'(8'(8'h80 + i)));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("wrap_count0", 32'(std_count), 32'd0);
    end

    // FWFT: word visible the cycle after the write, without rd_en
    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fwft_data",  32'(fw_data),  32'h3C);
    check("fwft_empty", 32'(fw_empty), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fwft_pop_empty", 32'(fw_empty), 32'd1);
    check("fwft_pop_data",  32'(fw_data),  32'd0);
    @(negedge clk); #1;

    // Asynchronous reset between edges at count=7
    for (int i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", 32'(std_count), 32'd7);
    check("pre_rst_data",  32'(std_data),  32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(std_count), 32'd0);
    check("arst_empty", 32'(std_empty), 32'd1);
    check("arst_data",  32'(std_data),  32'd0);
    check("arst_fw_data", 32'(fw_data), 32'd0);
    model.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush beats a concurrent write
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_flush_count", 32'(std_count), 32'd2);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    model.delete();
    check("flush_wr_count", 32'(std_count), 32'd0);
    check("flush_wr_empty", 32'(std_empty), 32'd1);
    check("flush_wr_fw",    32'(fw_data),   32'd0);

    @(negedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the general-purpose buffer for all single-clock datapaths, replacing fixed 4x8 instances.
- Adds configurable width and depth, programmable almost-full and almost-empty thresholds, and a first-word-fall-through option.
- Adds an occupancy output, sticky overflow/underflow error flags and a synchronous flush.
- Guarantees correct occupancy on simultaneous read and write.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of words; power of two, >=2
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  reset; asynchronous, active-low
flush  in  1  synchronous clear of FIFO contents and error flags
wr_en  in  1  write request
data_in  in  DATA_W  write data
rd_en  in  1  read request (pop)
data_out  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Storage: DEPTH x DATA_W array, not reset. Read/write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate registered counter.
- Reset (rst_n low, asynchronous): pointers = 0, count = 0, data_out = 0, overflow = 0, underflow = 0. Resulting flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Acceptance, evaluated per cycle:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc). A write into a full FIFO is accepted if a read is accepted in the same cycle.
  - A read from an empty FIFO is always rejected, even when a write occurs in the same cycle.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read, FWFT=0: on rd_acc, data_out <= mem[rd_ptr] (one-cycle latency) and rd_ptr increments. data_out holds its value otherwise, including on rejected reads.
- Read, FWFT=1: data_out = mem[rd_ptr] whenever !empty, and is 0 when empty. rd_acc pops and rd_ptr increments. A word written into an empty FIFO appears on data_out and empty deasserts in the cycle after the write edge.
- Flags: full, empty, almost_full, almost_empty are decoded combinationally from registered count only, so they are glitch-free relative to clk.
- Errors:
  - overflow <= 1 on wr_en & !wr_acc; underflow <= 1 on rd_en & !rd_acc.
  - Both stay set until flush or reset. Rejected operations do not change pointers, count or memory.
- Flush: synchronous. It has priority over wr_en and rd_en in the same cycle. Effects: pointers = 0, count = 0, overflow = 0, underflow = 0, data_out = 0 (FWFT=0). Memory contents are not cleared.
- Reset mid-operation: all state in the reset list clears immediately on rst_n falling, regardless of clk. Data written before reset is lost.

Test Plan:
- Fill/drain with defaults: write 0x01..0x10 (16 words) with no reads.
  - Expected: full=1, count=16, almost_full first high after the 14th write.
  - Then read 16 times: data_out sequence 0x01..0x10, each one cycle after its read (FWFT=0). empty=1 at the end; almost_empty high from count=2.
- Overflow/underflow: on a full FIFO, write 0xAA.
  - Expected: overflow=1, count stays 16, 0xAA is never read out.
  - Then on an empty FIFO, read: underflow=1, data_out unchanged. A following flush clears both flags.
- Simultaneous read/write:
  - At count=16, wr_en=rd_en=1 with 0x55: count stays 16, no overflow, 0x55 is read out last.
  - At count=0, wr_en=rd_en=1: count=1, underflow=1.
- Pointer wrap: perform 40 interleaved write/read pairs with incrementing data.
  - Expected: output order matches input with no loss; count stays at 0 or 1.
- FWFT=1: write 0x3C into an empty FIFO.
  - Expected: in the next cycle data_out=0x3C and empty=0 with no rd_en. Asserting rd_en then gives empty=1 and data_out=0 on the following cycle.
- Async reset and flush: assert rst_n low between clock edges at count=7.
  - Expected: count=0, empty=1 and data_out=0 immediately.
  - A flush asserted together with wr_en: the write is ignored and count=0.
